dice_roller: RTL



---
 rtl/dice_roller.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dice_roller.sv
// dice_roller: turns a raw, bouncy push-button into a dice throw.
// While the button is held the face spins through 1..6. On release the
// spin slows over SLOW_STEPS advances, each one longer than the last,
// and then settles.
//
// Ports:
//   Clk     - single clock, all logic on its rising edge
//   Reset   - synchronous, active-high reset
//   RollBtn - raw push-button, asynchronous to Clk, active-high
//   BinOut  - current face: 0 (blank, before the first throw) or 1..6
//   Rolling - high while the face is spinning or slowing down
//   Done    - one-cycle pulse once the final face has settled
module dice_roller #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ROLL_DIV        = 2500000,
  parameter int SLOW_STEPS      = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       RollBtn,
  output logic [3:0] BinOut,
  output logic       Rolling,
  output logic       Done
);

  localparam int TICK_W = $clog2(ROLL_DIV * (SLOW_STEPS + 1)) + 1;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int STEP_W = $clog2(SLOW_STEPS + 1) + 1;

  localparam logic [TICK_W-1:0] ROLL_LAST = TICK_W'(ROLL_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SLOW_STEPS);

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    SLOW
  } state_t;

  logic              btn_meta;
  logic              btn_sync;
  logic              btn_clean;
  logic              btn_clean_d;
  logic [DB_W-1:0]   db_count;
  logic              btn_rise;

  state_t            state;
  state_t            next_state;
  logic [TICK_W-1:0] tick;
  logic [TICK_W-1:0] next_tick;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] next_step;
  logic [TICK_W-1:0] slow_limit;
  logic              advance;
  logic              finish;
  logic [3:0]        next_face;

  // Two-flop synchronizer followed by a debouncer: the clean level only
  // follows the synchronized button after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement, so short bounces just reset the counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      btn_meta    <= 1'b0;
      btn_sync    <= 1'b0;
      btn_clean   <= 1'b0;
      btn_clean_d <= 1'b0;
      db_count    <= '0;
    end else begin
      btn_meta    <= RollBtn;
      btn_sync    <= btn_meta;
      btn_clean_d <= btn_clean;
      if (btn_sync == btn_clean) begin
        db_count <= '0;
      end else if (db_count == DB_LAST) begin
        btn_clean <= btn_sync;
        db_count  <= '0;
      end else begin
        db_count <= db_count + DB_W'(1);
      end
    end
  end

  // Edge, not level: a button already held when IDLE is re-entered
  // must not start a new throw.
  assign btn_rise = btn_clean & ~btn_clean_d;

  // SLOW step k waits ROLL_DIV*(k+1) cycles, so each advance is one
  // ROLL_DIV period longer than the previous one.
  assign slow_limit = TICK_W'(ROLL_DIV * (int'(step) + 1) - 1);

  always_comb begin
    next_state = state;
    next_tick  = tick;
    next_step  = step;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        next_tick = '0;
        next_step = '0;
        if (btn_rise) begin
          next_state = ROLL;
        end
      end
      ROLL: begin
        // Release takes priority; the hand-off cycle never advances.
        if (!btn_clean) begin
          next_state = SLOW;
          next_tick  = '0;
          next_step  = STEP_W'(1);
        end else if (tick == ROLL_LAST) begin
          advance   = 1'b1;
          next_tick = '0;
        end else begin
          next_tick = tick + TICK_W'(1);
        end
      end
      SLOW: begin
        if (tick == slow_limit) begin
          advance   = 1'b1;
          next_tick = '0;
          if (step == LAST_STEP) begin
            next_state = IDLE;
            next_step  = '0;
            finish     = 1'b1;
          end else begin
            next_step = step + STEP_W'(1);
          end
        end else begin
          next_tick = tick + TICK_W'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_tick  = '0;
        next_step  = '0;
      end
    endcase
  end

  // Faces cycle 1..6; blank (0) only exists until the first advance.
  always_comb begin
    next_face = BinOut;
    if (advance) begin
      next_face = (BinOut == 4'd6) ? 4'd1 : BinOut + 4'd1;
    end
  end

  // Outputs are registered from next-state values so Rolling and Done
  // change on the very edge the FSM moves.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      tick    <= '0;
      step    <= '0;
      BinOut  <= 4'd0;
      Rolling <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= next_state;
      tick    <= next_tick;
      step    <= next_step;
      BinOut  <= next_face;
      Rolling <= (next_state != IDLE);
      Done    <= finish;
    end
  end

endmodule
